ps2_poly_decoder: RTL and testbench

- Clocked, parametrised successor to the single-note PS/2 key decoder.
- Consumes the raw byte stream from the PS/2 receiver and parses make, break (F0) and extended (E0) sequences.
- Tracks up to NUM_VOICES simultaneously held note keys, assigning each to a voice slot.
- Emits edge-clean control strobes, and control state that is immune to typematic repeat, for the synth voice and ADSR blocks.

---
 rtl/ps2_poly_decoder.sv | 238 +++++++++++++++++++++++
 tb/tb_ps2_poly_decoder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_poly_decoder.sv
// ps2_poly_decoder: parses the PS/2 byte stream (make, F0 break, E0 extended),
// tracks up to NUM_VOICES held note keys in voice slots, and turns control keys
// into single-cycle strobes or latched settings that ignore typematic repeat.
module ps2_poly_decoder #(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 4,
    parameter int ADSR_SEL_W = 3,
    parameter int OD_W       = 2
) (
    input  logic                           CLOCK_50,
    input  logic                           resetn,
    input  logic [7:0]                     scan_code,
    input  logic                           scan_valid,
    output logic [NUM_VOICES*NOTE_W-1:0]   voice_note,
    output logic [NUM_VOICES-1:0]          voice_active,
    output logic [NUM_VOICES-1:0]          voice_on,
    output logic                           voice_full,
    output logic                           octave_minus_minus,
    output logic                           octave_plus_plus,
    output logic                           ADSR_minus_minus,
    output logic                           ADSR_plus_plus,
    output logic [ADSR_SEL_W-1:0]          ADSR_selector,
    output logic                           sine,
    output logic [OD_W-1:0]                overdrive,
    output logic                           hold
);

    localparam int SLOT_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int NUM_CTRL = 13;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } parse_state_t;

    parse_state_t state;
    parse_state_t next_state;

    logic                do_make;
    logic                do_break;
    logic                note_hit;
    logic [NOTE_W-1:0]   note_idx;
    logic                ctrl_hit;
    logic [3:0]          ctrl_idx;
    logic                match_hit;
    logic [SLOT_W-1:0]   match_idx;
    logic                free_hit;
    logic [SLOT_W-1:0]   free_idx;

    logic [NOTE_W-1:0]   notes [NUM_VOICES];
    logic [NUM_VOICES-1:0] keydown;
    logic [NUM_CTRL-1:0] pressed;

    // Parser state register; reset aborts any partial F0/E0 sequence.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Parser next state: prefix bytes move forward, any final byte returns to IDLE.
    always_comb begin
        next_state = state;
        if (scan_valid) begin
            case (state)
                IDLE: begin
                    if (scan_code == 8'hF0)      next_state = BRK;
                    else if (scan_code == 8'hE0) next_state = EXT;
                    else                         next_state = IDLE;
                end
                BRK:     next_state = IDLE;
                EXT:     next_state = (scan_code == 8'hF0) ? EXT_BRK : IDLE;
                EXT_BRK: next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Parser outputs: a plain make or plain break; extended keys produce neither.
    always_comb begin
        do_make  = 1'b0;
        do_break = 1'b0;
        if (scan_valid) begin
            if (state == IDLE && scan_code != 8'hF0 && scan_code != 8'hE0) do_make = 1'b1;
            if (state == BRK) do_break = 1'b1;
        end
    end

    // Map a scan code onto one of the twelve chromatic notes.
    always_comb begin
        note_hit = 1'b1;
        note_idx = '0;
        case (scan_code)
            8'h1C: note_idx = NOTE_W'(0);
            8'h1D: note_idx = NOTE_W'(1);
            8'h1B: note_idx = NOTE_W'(2);
            8'h24: note_idx = NOTE_W'(3);
            8'h23: note_idx = NOTE_W'(4);
            8'h2B: note_idx = NOTE_W'(5);
            8'h2C: note_idx = NOTE_W'(6);
            8'h34: note_idx = NOTE_W'(7);
            8'h35: note_idx = NOTE_W'(8);
            8'h33: note_idx = NOTE_W'(9);
            8'h3C: note_idx = NOTE_W'(10);
            8'h3B: note_idx = NOTE_W'(11);
            default: note_hit = 1'b0;
        endcase
    end

    // Map a scan code onto its bit in the control-key pressed bitmap.
    always_comb begin
        ctrl_hit = 1'b1;
        ctrl_idx = 4'd0;
        case (scan_code)
            8'h1A: ctrl_idx = 4'd0;
            8'h22: ctrl_idx = 4'd1;
            8'h21: ctrl_idx = 4'd2;
            8'h2A: ctrl_idx = 4'd3;
            8'h16: ctrl_idx = 4'd4;
            8'h1E: ctrl_idx = 4'd5;
            8'h26: ctrl_idx = 4'd6;
            8'h25: ctrl_idx = 4'd7;
            8'h2E: ctrl_idx = 4'd8;
            8'h36: ctrl_idx = 4'd9;
            8'h3D: ctrl_idx = 4'd10;
            8'h3E: ctrl_idx = 4'd11;
            8'h0D: ctrl_idx = 4'd12;
            default: ctrl_hit = 1'b0;
        endcase
    end

    // Find the lowest active slot holding this note and the lowest free slot.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (voice_active[i] && notes[i] == note_idx) begin
                match_hit = 1'b1;
                match_idx = SLOT_W'(i);
            end
            if (!voice_active[i]) begin
                free_hit = 1'b1;
                free_idx = SLOT_W'(i);
            end
        end
    end

    // Slot bookkeeping, control settings and single-cycle strobes.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_VOICES; i++) notes[i] <= '0;
            voice_active       <= '0;
            keydown            <= '0;
            pressed            <= '0;
            voice_on           <= '0;
            voice_full         <= 1'b0;
            octave_minus_minus <= 1'b0;
            octave_plus_plus   <= 1'b0;
            ADSR_minus_minus   <= 1'b0;
            ADSR_plus_plus     <= 1'b0;
            ADSR_selector      <= '0;
            sine               <= 1'b0;
            overdrive          <= '0;
            hold               <= 1'b0;
        end else begin
            voice_on           <= '0;
            voice_full         <= 1'b0;
            octave_minus_minus <= 1'b0;
            octave_plus_plus   <= 1'b0;
            ADSR_minus_minus   <= 1'b0;
            ADSR_plus_plus     <= 1'b0;

            if (do_make && note_hit) begin
                if (match_hit) begin
                    keydown[match_idx] <= 1'b1;
                end else if (free_hit) begin
                    voice_active[free_idx] <= 1'b1;
                    keydown[free_idx]      <= 1'b1;
                    notes[free_idx]        <= note_idx;
                    voice_on[free_idx]     <= 1'b1;
                end else begin
                    voice_full <= 1'b1;
                end
            end

            if (do_break && note_hit && match_hit) begin
                keydown[match_idx] <= 1'b0;
                if (!hold) voice_active[match_idx] <= 1'b0;
            end

            if (do_make && ctrl_hit && !pressed[ctrl_idx]) begin
                pressed[ctrl_idx] <= 1'b1;
                case (scan_code)
                    8'h1A: octave_minus_minus <= 1'b1;
                    8'h22: octave_plus_plus   <= 1'b1;
                    8'h21: ADSR_minus_minus   <= 1'b1;
                    8'h2A: ADSR_plus_plus     <= 1'b1;
                    8'h16: ADSR_selector      <= ADSR_SEL_W'(0);
                    8'h1E: ADSR_selector      <= ADSR_SEL_W'(1);
                    8'h26: ADSR_selector      <= ADSR_SEL_W'(2);
                    8'h25: ADSR_selector      <= ADSR_SEL_W'(3);
                    8'h2E: ADSR_selector      <= ADSR_SEL_W'(4);
                    8'h36: sine               <= ~sine;
                    8'h3D: overdrive          <= overdrive ^ OD_W'(1);
                    8'h3E: overdrive          <= overdrive ^ OD_W'(2);
                    8'h0D: begin
                        hold <= ~hold;
                        if (hold) begin
                            for (int i = 0; i < NUM_VOICES; i++) begin
                                if (!keydown[i]) voice_active[i] <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end

            if (do_break && ctrl_hit) begin
                pressed[ctrl_idx] <= 1'b0;
            end
        end
    end

    // Flatten the per-slot notes onto the packed output bus.
    always_comb begin
        voice_note = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_note[i*NOTE_W +: NOTE_W] = notes[i];
        end
    end

endmodule

// File: tb/tb_ps2_poly_decoder.sv
// tb_ps2_poly_decoder: directed byte streams with hand-computed expected
// output snapshots queued per byte; a monitor compares after each consumed byte.
module tb_ps2_poly_decoder;

    typedef struct packed {
        logic [15:0] note;
        logic [3:0]  active;
        logic [3:0]  on;
        logic        full;
        logic        om;
        logic        op;
        logic        am;
        logic        ap;
        logic [2:0]  sel;
        logic        sine;
        logic [1:0]  od;
        logic        hold;
    } snap_t;

    logic        CLOCK_50 = 1'b0;
    logic        resetn = 1'b1;
    logic [7:0]  scan_code = 8'h00;
    logic        scan_valid = 1'b0;
    logic [15:0] voice_note;
    logic [3:0]  voice_active;
    logic [3:0]  voice_on;
    logic        voice_full;
    logic        octave_minus_minus;
    logic        octave_plus_plus;
    logic        ADSR_minus_minus;
    logic        ADSR_plus_plus;
    logic [2:0]  ADSR_selector;
    logic        sine;
    logic [1:0]  overdrive;
    logic        hold;

    snap_t       exp_q [$];
    string       name_q [$];
    snap_t       exp;
    logic        seen = 1'b0;
    logic        snap_req = 1'b0;
    logic        mon_en = 1'b0;
    int          errors = 0;
    int          checks = 0;

    ps2_poly_decoder #(
        .NUM_VOICES(4), .NOTE_W(4), .ADSR_SEL_W(3), .OD_W(2)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .resetn(resetn),
        .scan_code(scan_code),
        .scan_valid(scan_valid),
        .voice_note(voice_note),
        .voice_active(voice_active),
        .voice_on(voice_on),
        .voice_full(voice_full),
        .octave_minus_minus(octave_minus_minus),
        .octave_plus_plus(octave_plus_plus),
        .ADSR_minus_minus(ADSR_minus_minus),
        .ADSR_plus_plus(ADSR_plus_plus),
        .ADSR_selector(ADSR_selector),
        .sine(sine),
        .overdrive(overdrive),
        .hold(hold)
    );

    // 50 MHz clock
    always #10 CLOCK_50 = ~CLOCK_50;

    // Remember whether the DUT consumed a byte on this edge
    always @(posedge CLOCK_50) seen <= scan_valid;

    function automatic snap_t actual_snap();
        snap_t s;
        s.note   = voice_note;
        s.active = voice_active;
        s.on     = voice_on;
        s.full   = voice_full;
        s.om     = octave_minus_minus;
        s.op     = octave_plus_plus;
        s.am     = ADSR_minus_minus;
        s.ap     = ADSR_plus_plus;
        s.sel    = ADSR_selector;
        s.sine   = sine;
        s.od     = overdrive;
        s.hold   = hold;
        return s;
    endfunction

    task automatic check_output(input string name, input snap_t want);
        snap_t got;
        got = actual_snap();
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got note=%h act=%b on=%b full=%b om=%b op=%b am=%b ap=%b sel=%0d sine=%b od=%b hold=%b, want note=%h act=%b on=%b full=%b om=%b op=%b am=%b ap=%b sel=%0d sine=%b od=%b hold=%b",
                     name, got.note, got.active, got.on, got.full, got.om, got.op, got.am, got.ap, got.sel, got.sine, got.od, got.hold,
                     want.note, want.active, want.on, want.full, want.om, want.op, want.am, want.ap, want.sel, want.sine, want.od, want.hold);
        end
    endtask

    // Monitor: pop and compare after each consumed byte; otherwise strobes must be low
    always @(negedge CLOCK_50) begin
        if (mon_en) begin
            if (seen || snap_req) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL scoreboard_empty: got output event, want queued expectation");
                end else begin
                    check_output(name_q.pop_front(), exp_q.pop_front());
                end
            end else begin
                checks++;
                if ({voice_on, voice_full, octave_minus_minus, octave_plus_plus,
                     ADSR_minus_minus, ADSR_plus_plus} !== 9'b0) begin
                    errors++;
                    $display("[TB] FAIL idle_strobes: got on=%b full=%b om=%b op=%b am=%b ap=%b, want all 0",
                             voice_on, voice_full, octave_minus_minus, octave_plus_plus,
                             ADSR_minus_minus, ADSR_plus_plus);
                end
            end
        end
    end

    // Queue the expected snapshot, drive one byte for one cycle, then clear strobe fields
    task automatic apply_stimulus(input logic [7:0] code, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        scan_code  = code;
        scan_valid = 1'b1;
        @(posedge CLOCK_50);
        #1;
        scan_valid = 1'b0;
        exp.on   = 4'b0;
        exp.full = 1'b0;
        exp.om   = 1'b0;
        exp.op   = 1'b0;
        exp.am   = 1'b0;
        exp.ap   = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Hold reset low, request an all-zero snapshot while in reset, then release
    task automatic reset_and_check(input string name);
        idle_cycle();
        resetn = 1'b0;
        exp = '0;
        idle_cycle();
        exp_q.push_back(exp);
        name_q.push_back(name);
        snap_req = 1'b1;
        idle_cycle();
        snap_req = 1'b0;
        resetn = 1'b1;
        idle_cycle();
    endtask

    initial begin
        exp = '0;
        #3;
        resetn = 1'b0;
        idle_cycle();
        mon_en = 1'b1;
        reset_and_check("reset_state");

        // Two makes then a break of the first note
        exp.active = 4'b0001; exp.on = 4'b0001; exp.note = 16'h0000;
        apply_stimulus(8'h1C, "make_1C");
        exp.active = 4'b0011; exp.on = 4'b0010; exp.note = 16'h0020;
        apply_stimulus(8'h1B, "make_1B");
        apply_stimulus(8'hF0, "brk_prefix");
        exp.active = 4'b0010;
        apply_stimulus(8'h1C, "brk_1C");
        apply_stimulus(8'hF0, "brk_prefix");
        exp.active = 4'b0000;
        apply_stimulus(8'h1B, "brk_1B");
        idle_cycle();

        // Fill all four slots, repeat one, overflow with a fifth
        exp.active = 4'b0001; exp.on = 4'b0001;
        apply_stimulus(8'h1C, "fill_1C");
        exp.active = 4'b0011; exp.on = 4'b0010;
        apply_stimulus(8'h1B, "fill_1B");
        exp.active = 4'b0111; exp.on = 4'b0100; exp.note = 16'h0420;
        apply_stimulus(8'h23, "fill_23");
        exp.active = 4'b1111; exp.on = 4'b1000; exp.note = 16'h5420;
        apply_stimulus(8'h2B, "fill_2B");
        apply_stimulus(8'h1B, "repeat_1B");
        exp.full = 1'b1;
        apply_stimulus(8'h34, "overflow_34");
        apply_stimulus(8'hF0, "brk_prefix");
        apply_stimulus(8'h34, "brk_unheld_34");
        apply_stimulus(8'hF0, "brk_prefix");
        exp.active = 4'b1110;
        apply_stimulus(8'h1C, "release_1C");
        apply_stimulus(8'hF0, "brk_prefix");
        exp.active = 4'b1100;
        apply_stimulus(8'h1B, "release_1B");
        apply_stimulus(8'hF0, "brk_prefix");
        exp.active = 4'b1000;
        apply_stimulus(8'h23, "release_23");
        apply_stimulus(8'hF0, "brk_prefix");
        exp.active = 4'b0000;
        apply_stimulus(8'h2B, "release_2B");
        idle_cycle();

        // Sine toggle immune to typematic repeat
        exp.sine = 1'b1;
        apply_stimulus(8'h36, "sine_on");
        apply_stimulus(8'h36, "sine_repeat1");
        apply_stimulus(8'h36, "sine_repeat2");
        apply_stimulus(8'hF0, "brk_prefix");
        apply_stimulus(8'h36, "sine_brk");
        exp.sine = 1'b0;
        apply_stimulus(8'h36, "sine_off");
        apply_stimulus(8'hF0, "brk_prefix");
        apply_stimulus(8'h36, "sine_brk2");

        // Strobe and setting keys
        exp.om = 1'b1;
        apply_stimulus(8'h1A, "oct_minus");
        apply_stimulus(8'h1A, "oct_minus_repeat");
        apply_stimulus(8'hF0, "brk_prefix");
        apply_stimulus(8'h1A, "oct_minus_brk");
        exp.om = 1'b1;
        apply_stimulus(8'h1A, "oct_minus_again");
        exp.op = 1'b1;
        apply_stimulus(8'h22, "oct_plus");
        exp.am = 1'b1;
        apply_stimulus(8'h21, "adsr_minus");
        exp.ap = 1'b1;
        apply_stimulus(8'h2A, "adsr_plus");
        exp.sel = 3'd4;
        apply_stimulus(8'h2E, "sel_4");
        exp.sel = 3'd3;
        apply_stimulus(8'h25, "sel_3");
        exp.od = 2'b01;
        apply_stimulus(8'h3D, "od_bit0");
        exp.od = 2'b11;
        apply_stimulus(8'h3E, "od_bit1");
        apply_stimulus(8'h5A, "unmapped_make");
        idle_cycle();

        // Sustain: released key stays until hold is dropped; held key survives
        exp.hold = 1'b1;
        apply_stimulus(8'h0D, "hold_on");
        exp.active = 4'b0001; exp.on = 4'b0001;
        apply_stimulus(8'h1C, "hold_make_1C");
        exp.active = 4'b0011; exp.on = 4'b0010;
        apply_stimulus(8'h1B, "hold_make_1B");
        apply_stimulus(8'hF0, "brk_prefix");
        apply_stimulus(8'h1C, "hold_brk_1C");
        apply_stimulus(8'hF0, "brk_prefix");
        apply_stimulus(8'h0D, "hold_key_brk");
        exp.hold = 1'b0; exp.active = 4'b0010;
        apply_stimulus(8'h0D, "hold_off");
        apply_stimulus(8'hF0, "brk_prefix");
        exp.active = 4'b0000;
        apply_stimulus(8'h1B, "brk_1B_after_hold");
        idle_cycle();

        // Extended sequences are discarded
        apply_stimulus(8'hE0, "ext_prefix");
        apply_stimulus(8'h1C, "ext_make");
        apply_stimulus(8'hE0, "ext_prefix");
        apply_stimulus(8'hF0, "ext_brk_prefix");
        apply_stimulus(8'h1C, "ext_brk");
        exp.active = 4'b0001; exp.on = 4'b0001;
        apply_stimulus(8'h1C, "make_after_ext");
        apply_stimulus(8'hF0, "brk_prefix");
        exp.active = 4'b0000;
        apply_stimulus(8'h1C, "brk_after_ext");

        // Reset between F0 and its code byte; following 1C is a make
        apply_stimulus(8'hF0, "brk_prefix_pre_reset");
        reset_and_check("reset_mid_break");
        exp.active = 4'b0001; exp.on = 4'b0001; exp.note = 16'h0000;
        apply_stimulus(8'h1C, "make_after_reset");
        idle_cycle();
        idle_cycle();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
